// File: rtl/ct_f_spsram_4096x32_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ct_f_spsram_4096x32_ctrl_pkg
// Description : Shared definitions for the 4096x32 single-port SRAM
//               requester-side controller: FSM encoding, default geometry
//               and the byte-lane count used for bmask -> WEN expansion.
// Contents    : state_t            controller FSM states (INIT, READY)
//               DEF_ADDR_WIDTH     default SRAM word address width
//               DEF_WRAP_SIZE      default byte-lane width
//               DEF_RSP_DEPTH      default response FIFO depth
//               NUM_LANES          byte lanes per word
// Revision    : 1.0 - initial release
// ============================================================================
package ct_f_spsram_4096x32_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_WRAP_SIZE  = 8;
  localparam int DEF_RSP_DEPTH  = 2;

  // One WEN byte field per request mask bit.
  localparam int NUM_LANES      = 4;

endpackage
`default_nettype wire

// File: rtl/ct_f_spsram_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ct_f_spsram_rsp_fifo
// Description : Synchronous response FIFO with head-output data. Push and
//               pop may occur in the same cycle at any occupancy. The
//               caller guarantees by credit that it never pushes when full.
// Ports       : clk      in   clock
//               rst_n    in   asynchronous active-low reset
//               i_push   in   write i_wdata into the tail
//               i_wdata  in   WIDTH-bit push data
//               i_pop    in   remove head entry (ignored when empty)
//               o_rdata  out  head entry
//               o_cnt    out  current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module ct_f_spsram_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH+1)-1:0] o_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic             w_pop;
  logic [PTR_W-1:0] w_wr_nxt;
  logic [PTR_W-1:0] w_rd_nxt;

  assign w_pop    = i_pop && (r_cnt != '0);
  // Explicit wrap keeps non-power-of-two depths correct.
  assign w_wr_nxt = (r_wr_ptr == PTR_W'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_nxt = (r_rd_ptr == PTR_W'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= w_wr_nxt;
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through o_cnt.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: rtl/ct_f_spsram_4096x32_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ct_f_spsram_4096x32_ctrl
// Description : Requester-side controller for the 4096x32 single-port SRAM
//               macro. Accepts read/write requests on a valid/ready channel,
//               drives the macro's active-low CEN/GWEN/WEN pins and returns
//               read data through a credit-protected response FIFO.
// Build macro : SPSRAM_CTRL_INIT_EN - when defined, zero-fills the whole
//               array after reset before accepting traffic.
// Ports       : CLK, RST_B                  clock, async active-low reset
//               req_vld/req_rdy/req_wr/req_addr/req_wdata/req_bmask
//                                           request channel
//               rsp_vld/rsp_rdy/rsp_rdata   read response channel
//               init_done                   ready for traffic
//               A/CEN/GWEN/WEN/D            SRAM macro drive
//               Q                           SRAM read data (1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module ct_f_spsram_4096x32_ctrl
  import ct_f_spsram_4096x32_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WRAP_SIZE  = DEF_WRAP_SIZE,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
  input  logic                          CLK,
  input  logic                          RST_B,
  input  logic                          req_vld,
  output logic                          req_rdy,
  input  logic                          req_wr,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [NUM_LANES*WRAP_SIZE-1:0] req_wdata,
  input  logic [NUM_LANES-1:0]          req_bmask,
  output logic                          rsp_vld,
  input  logic                          rsp_rdy,
  output logic [NUM_LANES*WRAP_SIZE-1:0] rsp_rdata,
  output logic                          init_done,
  output logic [ADDR_WIDTH-1:0]         A,
  output logic                          CEN,
  output logic                          GWEN,
  output logic [NUM_LANES*WRAP_SIZE-1:0] WEN,
  output logic [NUM_LANES*WRAP_SIZE-1:0] D,
  input  logic [NUM_LANES*WRAP_SIZE-1:0] Q
);

  localparam int DW    = NUM_LANES * WRAP_SIZE;
  localparam int CNT_W = $clog2(RSP_DEPTH+1);

  state_t                r_state;
  logic                  r_init_done;
  logic                  r_rd_pend;

  logic                  w_init_wr;
  logic [ADDR_WIDTH-1:0] w_init_addr;
  logic                  w_accept;
  logic                  w_wr_acc;
  logic                  w_pop;
  logic                  w_credit_ok;
  logic [CNT_W-1:0]      w_fifo_cnt;
  logic [CNT_W:0]        w_occ;
  logic [CNT_W:0]        w_occ_net;
  logic [DW-1:0]         w_wen_wr;

  // --------------------------------------------------------------------------
  // FSM and init sequencing
  // --------------------------------------------------------------------------
`ifdef SPSRAM_CTRL_INIT_EN
  // r_init_run stays low in reset so the pins are idle while RST_B is low;
  // the walk starts on the first edge after release.
  logic                  r_init_run;
  logic [ADDR_WIDTH-1:0] r_init_addr;

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      r_state     <= ST_INIT;
      r_init_done <= 1'b0;
      r_init_run  <= 1'b0;
      r_init_addr <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (!r_init_run) begin
            r_init_run <= 1'b1;
          end else if (r_init_addr == {ADDR_WIDTH{1'b1}}) begin
            r_init_run  <= 1'b0;
            r_state     <= ST_READY;
            r_init_done <= 1'b1;
          end else begin
            r_init_addr <= r_init_addr + 1'b1;
          end
        end
        ST_READY: r_state <= ST_READY;
        default:  r_state <= ST_INIT;
      endcase
    end
  end

  assign w_init_wr   = r_init_run;
  assign w_init_addr = r_init_addr;
`else
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      r_state     <= ST_INIT;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_state     <= ST_READY;
          r_init_done <= 1'b1;
        end
        ST_READY: r_state <= ST_READY;
        default:  r_state <= ST_INIT;
      endcase
    end
  end

  assign w_init_wr   = 1'b0;
  assign w_init_addr = '0;
`endif

  // --------------------------------------------------------------------------
  // Credit: count FIFO entries plus the read whose data is still on Q, minus
  // the entry leaving this cycle. Writes are gated the same way to keep
  // request ordering trivial.
  // --------------------------------------------------------------------------
  assign w_pop       = rsp_vld && rsp_rdy;
  assign w_occ       = {1'b0, w_fifo_cnt} + {{CNT_W{1'b0}}, r_rd_pend};
  assign w_occ_net   = w_occ - {{CNT_W{1'b0}}, w_pop};
  assign w_credit_ok = (w_occ_net < (CNT_W+1)'(RSP_DEPTH));

  assign req_rdy     = r_init_done && w_credit_ok;
  assign w_accept    = req_vld && req_rdy;
  assign w_wr_acc    = w_accept && req_wr;

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) r_rd_pend <= 1'b0;
    else        r_rd_pend <= w_accept && !req_wr;
  end

  // --------------------------------------------------------------------------
  // SRAM pin drive
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign w_wen_wr[gi*WRAP_SIZE +: WRAP_SIZE] = {WRAP_SIZE{~req_bmask[gi]}};
  end

  assign CEN  = ~(w_accept | w_init_wr);
  assign GWEN = ~(w_init_wr | w_wr_acc);
  assign WEN  = w_init_wr ? '0 : (w_wr_acc ? w_wen_wr : '1);
  assign D    = w_init_wr ? '0 : req_wdata;
  assign A    = w_init_wr ? w_init_addr : req_addr;

  // --------------------------------------------------------------------------
  // Response FIFO: Q is captured the cycle after the read access.
  // --------------------------------------------------------------------------
  ct_f_spsram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DW)
  ) u_rsp_fifo (
    .clk     (CLK),
    .rst_n   (RST_B),
    .i_push  (r_rd_pend),
    .i_wdata (Q),
    .i_pop   (w_pop),
    .o_rdata (rsp_rdata),
    .o_cnt   (w_fifo_cnt)
  );

  assign rsp_vld   = (w_fifo_cnt != '0);
  assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_ct_f_spsram_4096x32_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ct_f_spsram_4096x32_ctrl
// Description : Self-checking bench for ct_f_spsram_4096x32_ctrl with a
//               behavioural SRAM macro, a vector table for single accesses,
//               hand-written backpressure/throughput/reset sequences and a
//               response scoreboard. Honours SPSRAM_CTRL_INIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ct_f_spsram_4096x32_ctrl;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          CLK = 1'b0;
  logic          RST_B;
  logic          req_vld, req_rdy, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_bmask;
  logic          rsp_vld, rsp_rdy;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic [AW-1:0] A;
  logic          CEN, GWEN;
  logic [DW-1:0] WEN, D, Q;

  always #5 CLK = ~CLK;

  ct_f_spsram_4096x32_ctrl #(
    .ADDR_WIDTH (AW),
    .WRAP_SIZE  (8),
    .RSP_DEPTH  (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST_B     (RST_B),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_bmask (req_bmask),
    .rsp_vld   (rsp_vld),
    .rsp_rdy   (rsp_rdy),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .A         (A),
    .CEN       (CEN),
    .GWEN      (GWEN),
    .WEN       (WEN),
    .D         (D),
    .Q         (Q)
  );

  // Behavioural SRAM macro: bit-masked write, registered read.
  logic [DW-1:0] mem [1<<AW];
  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = $urandom;
    Q = '0;
  end
  always @(posedge CLK) begin
    if (CEN === 1'b0) begin
      if (GWEN === 1'b0) mem[A] <= (mem[A] & WEN) | (D & ~WEN);
      else               Q <= mem[A];
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected read data, pushed when a read is accepted.
  logic [31:0] exp_q[$];
  int          rsp_cyc_q[$];
  int          rsp_seen = 0;
  bit          ovf = 1'b0;

  always @(negedge CLK) begin
    if (RST_B === 1'b1 && rsp_vld === 1'b1 && rsp_rdy === 1'b1) begin
      rsp_seen++;
      rsp_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", rsp_rdata, 32'hxxxx_xxxx);
      end else begin
        chk("rsp_data", rsp_rdata, exp_q.pop_front());
      end
    end
  end

  always @(posedge CLK) if (exp_q.size() > DEPTH) ovf = 1'b1;

`ifdef SPSRAM_CTRL_INIT_EN
  int walk_cnt = 0;
  bit walk_bad = 1'b0;
  always @(negedge CLK) begin
    if (RST_B === 1'b1 && init_done === 1'b0 && CEN === 1'b0) begin
      if (A !== walk_cnt[AW-1:0] || D !== '0 || GWEN !== 1'b0 || WEN !== '0) walk_bad = 1'b1;
      walk_cnt++;
    end
  end
`endif

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic [31:0] exp_wen;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  typedef struct { logic [11:0] addr; logic [31:0] exp; } rd_t;
  rd_t rd_list[$];

  task automatic do_req(input vec_t v, input string tag);
    bit ok = 1'b0;
    req_vld = 1'b1; req_wr = v.wr; req_addr = v.addr;
    req_wdata = v.wdata; req_bmask = v.bmask;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge CLK);
      if (req_rdy === 1'b1) begin
        ok = 1'b1;
        chk({tag, "_cen"},  32'(CEN),  32'(1'b0));
        chk({tag, "_gwen"}, 32'(GWEN), 32'(!v.wr));
        chk({tag, "_wen"},  WEN, v.exp_wen);
        chk({tag, "_a"},    32'(A), 32'(v.addr));
        chk({tag, "_d"},    D, v.wdata);
        if (!v.wr) exp_q.push_back(v.exp_rdata);
      end
      @(posedge CLK); #1;
    end
    if (!ok) chk({tag, "_accept_timeout"}, 32'(ok), 32'(1'b1));
    req_vld = 1'b0;
  endtask

  task automatic present_reads(input int ncyc, output int nacc);
    nacc = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (rd_list.size() != 0) begin
        req_vld = 1'b1; req_wr = 1'b0; req_addr = rd_list[0].addr;
        @(negedge CLK);
        if (req_rdy === 1'b1) begin
          exp_q.push_back(rd_list[0].exp);
          void'(rd_list.pop_front());
          nacc++;
        end
      end else begin
        req_vld = 1'b0;
        @(negedge CLK);
      end
      @(posedge CLK); #1;
    end
    req_vld = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(posedge CLK);
    #1;
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_init(input string tag);
    bit done = 1'b0;
    for (int k = 0; k < 5000 && !done; k++) begin
      @(negedge CLK);
      done = (init_done === 1'b1);
    end
    chk({tag, "_init_done"}, 32'(done), 32'(1'b1));
    @(posedge CLK); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc;
    vec_t v;
    //            wr    addr     wdata          bmask    exp_wen        exp_rdata
    vecs[0]  = '{1'b1, 12'h123, 32'hDEADBEEF, 4'hF,    32'h00000000, 32'h0};
    vecs[1]  = '{1'b0, 12'h123, 32'h00000000, 4'h0,    32'hFFFFFFFF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 12'h123, 32'h11223344, 4'b0101, 32'hFF00FF00, 32'h0};
    vecs[3]  = '{1'b0, 12'h123, 32'h00000000, 4'h0,    32'hFFFFFFFF, 32'hDE22BE44};
    vecs[4]  = '{1'b1, 12'h000, 32'hCAFEF00D, 4'hF,    32'h00000000, 32'h0};
    vecs[5]  = '{1'b1, 12'hFFF, 32'h12345678, 4'hF,    32'h00000000, 32'h0};
    vecs[6]  = '{1'b0, 12'hFFF, 32'h00000000, 4'h0,    32'hFFFFFFFF, 32'h12345678};
    vecs[7]  = '{1'b0, 12'h000, 32'h00000000, 4'h0,    32'hFFFFFFFF, 32'hCAFEF00D};
    vecs[8]  = '{1'b1, 12'h000, 32'hFFFFFFFF, 4'h0,    32'hFFFFFFFF, 32'h0};
    vecs[9]  = '{1'b0, 12'h000, 32'h00000000, 4'h0,    32'hFFFFFFFF, 32'hCAFEF00D};
    vecs[10] = '{1'b1, 12'hFFF, 32'hAABBCCDD, 4'b1010, 32'h00FF00FF, 32'h0};
    vecs[11] = '{1'b0, 12'hFFF, 32'h00000000, 4'h0,    32'hFFFFFFFF, 32'hAA34CC78};

    RST_B = 1'b0; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
    req_wdata = '0; req_bmask = '0; rsp_rdy = 1'b1;
    #1;
    chk("rst_req_rdy",   32'(req_rdy),   32'd0);
    chk("rst_rsp_vld",   32'(rsp_vld),   32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_cen",       32'(CEN),       32'd1);
    chk("rst_gwen",      32'(GWEN),      32'd1);
    chk("rst_wen",       WEN,            32'hFFFFFFFF);
    repeat (3) @(posedge CLK);
    @(negedge CLK); RST_B = 1'b1;
    wait_init("boot");

`ifdef SPSRAM_CTRL_INIT_EN
    chk("init_walk_cnt", 32'(walk_cnt), 32'd4096);
    chk("init_walk_ok",  32'(walk_bad), 32'd0);
    v = '{1'b0, 12'h5A5, 32'h0, 4'h0, 32'hFFFFFFFF, 32'h00000000};
    do_req(v, "init_zero_rd");
    wait_drain("init_zero");
`endif

    // Table-driven single accesses, back to back.
    for (int i = 0; i < 12; i++) do_req(vecs[i], $sformatf("vec%0d", i));
    wait_drain("table");

    // Read latency: accept at N -> rsp_vld at N+2.
    v = '{1'b0, 12'h123, 32'h0, 4'h0, 32'hFFFFFFFF, 32'hDE22BE44};
    do_req(v, "lat");
    @(negedge CLK);
    chk("lat_n1_rsp_vld", 32'(rsp_vld), 32'd0);
    @(negedge CLK);
    chk("lat_n2_rsp_vld", 32'(rsp_vld), 32'd1);
    chk("lat_n2_rdata",   rsp_rdata,    32'hDE22BE44);
    @(posedge CLK); #1;
    wait_drain("lat");

    // Backpressure: only RSP_DEPTH reads accepted while rsp_rdy is low.
    rsp_rdy = 1'b0;
    rd_list.push_back('{12'h123, 32'hDE22BE44});
    rd_list.push_back('{12'hFFF, 32'hAA34CC78});
    rd_list.push_back('{12'h000, 32'hCAFEF00D});
    rd_list.push_back('{12'h123, 32'hDE22BE44});
    present_reads(6, nacc);
    chk("bp_accepted", 32'(nacc), 32'd2);
    @(negedge CLK);
    chk("bp_req_rdy", 32'(req_rdy), 32'd0);
    chk("bp_rsp_vld", 32'(rsp_vld), 32'd1);
    chk("bp_head",    rsp_rdata,    32'hDE22BE44);
    repeat (2) @(negedge CLK);
    chk("bp_head_stable", rsp_rdata, 32'hDE22BE44);
    @(posedge CLK); #1;
    rsp_rdy = 1'b1;
    present_reads(2, nacc);
    chk("bp_resume_rate", 32'(nacc), 32'd2);
    wait_drain("bp");

    // Throughput: 16 back-to-back reads with rsp_rdy held high.
    rsp_cyc_q.delete();
    for (int i = 0; i < 16; i++) begin
      case (i % 3)
        0:       rd_list.push_back('{12'h123, 32'hDE22BE44});
        1:       rd_list.push_back('{12'hFFF, 32'hAA34CC78});
        default: rd_list.push_back('{12'h000, 32'hCAFEF00D});
      endcase
    end
    present_reads(16, nacc);
    chk("tp_accepted", 32'(nacc), 32'd16);
    wait_drain("tp");
    chk("tp_rsp_count", 32'(rsp_cyc_q.size()), 32'd16);
    if (rsp_cyc_q.size() == 16)
      chk("tp_consecutive", 32'(rsp_cyc_q[15] - rsp_cyc_q[0]), 32'd15);

    // Reset asserted the cycle after a read accept.
    v = '{1'b0, 12'hFFF, 32'h0, 4'h0, 32'hFFFFFFFF, 32'hAA34CC78};
    do_req(v, "rstmid");
    RST_B = 1'b0;
    exp_q.delete();
    rsp_seen = 0;
`ifdef SPSRAM_CTRL_INIT_EN
    walk_cnt = 0;
`endif
    #1;
    chk("rstmid_rsp_vld", 32'(rsp_vld),   32'd0);
    chk("rstmid_cen",     32'(CEN),       32'd1);
    chk("rstmid_init",    32'(init_done), 32'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK); RST_B = 1'b1;
    wait_init("rstmid");
    repeat (10) @(posedge CLK);
    #1;
    chk("rstmid_no_rsp", 32'(rsp_seen), 32'd0);

    // Traffic works again after the mid-operation reset.
    v = '{1'b1, 12'h321, 32'h0BADCAFE, 4'hF, 32'h00000000, 32'h0};
    do_req(v, "post_wr");
    v = '{1'b0, 12'h321, 32'h0, 4'h0, 32'hFFFFFFFF, 32'h0BADCAFE};
    do_req(v, "post_rd");
    wait_drain("post");

    chk("no_overflow", 32'(ovf), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ct_f_spsram_4096x32_ctrl.md
# ct_f_spsram_4096x32_ctrl

Requester-side controller for the FPGA 4096x32 single-port SRAM macro. It accepts read/write requests on a valid/ready channel and drives the macro's active-low CEN/GWEN/WEN pins. Read data from the macro is returned through a credit-protected response FIFO. Optionally, it zero-fills the whole array after reset before accepting traffic. It sits between a cache/buffer client and the SRAM wrapper, and is the only driver of the wrapper's A/CEN/GWEN/WEN/D pins.

## Interface
Parameters:
- ADDR_WIDTH, 12, SRAM word address width (depth = 2^ADDR_WIDTH)
- WRAP_SIZE, 8, byte-lane width; data width is 4*WRAP_SIZE
- RSP_DEPTH, 2, response FIFO entries (minimum 2)

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  clock, shared with SRAM macro
- RST_B  in  1  asynchronous active-low reset
- req_vld  in  1  request valid
- req_rdy  out  1  request ready
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  4*WRAP_SIZE  write data
- req_bmask  in  4  per-byte write enable, 1 = write lane
- rsp_vld  out  1  read data valid
- rsp_rdy  in  1  read data accepted
- rsp_rdata  out  4*WRAP_SIZE  read data
- init_done  out  1  controller ready for traffic
- A  out  ADDR_WIDTH  SRAM address
- CEN  out  1  SRAM chip enable, active-low
- GWEN  out  1  SRAM global write enable, active-low
- WEN  out  4*WRAP_SIZE  SRAM bit write enables, active-low
- D  out  4*WRAP_SIZE  SRAM write data
- Q  in  4*WRAP_SIZE  SRAM read data, valid the cycle after a read access

## Operation
- FSM states: INIT, READY. Reset enters INIT.
- Request handshake: the request is accepted when req_vld && req_rdy, and the SRAM access is issued in that same cycle.
  - CEN = !(accept || init_wr).
  - A = req_addr.
  - D = req_wdata.
- Write: GWEN=0; WEN[8i+7:8i] = {8{~req_bmask[i]}}. A write produces no response. A write with bmask=0 still pulses CEN low and leaves memory unchanged.
- Read: GWEN=1, WEN all ones.
  - rd_pend register is set on read accept.
  - The following cycle, Q is pushed into the FIFO.
- Credit rule: req_rdy = init_done && (fifo_cnt + rd_pend - pop < RSP_DEPTH), where pop = rsp_vld && rsp_rdy. Reads and writes are gated identically so that ordering stays simple.
- FIFO behaviour:
  - Head drives rsp_rdata.
  - rsp_vld = (fifo_cnt != 0).
  - Push and pop in the same cycle are allowed at any occupancy.
  - Overflow is impossible by credit. The bench asserts that it never occurs.
- With RSP_DEPTH=2 and rsp_rdy held high, back-to-back reads sustain one per cycle.
- Idle cycles: CEN=1. A, D, GWEN and WEN follow request inputs/defaults, and their values are don't-care while CEN=1.

## Timing
- Reset values: req_rdy=0, rsp_vld=0, init_done=0, CEN=1, GWEN=1, WEN all ones, fifo_cnt=0, rd_pend=0.
- Read latency: accept in cycle N -> Q valid in N+1 -> rsp_vld/rsp_rdata in N+2.
- Write followed by read of the same address in the next cycle returns the new data.
- rsp_rdata stays stable while rsp_vld && !rsp_rdy.
- req_rdy is combinational on rsp_rdy (through pop). There is no combinational path from req_vld to req_rdy.
- Reset asserted mid-operation:
  - FIFO and rd_pend are cleared and any in-flight read is dropped.
  - The FSM returns to INIT. Memory contents are not guaranteed.

## Configuration
- SPSRAM_CTRL_INIT_EN defined:
  - INIT walks addresses 0..2^ADDR_WIDTH-1, one per cycle, with GWEN=0, WEN=0 and D=0.
  - init_done rises the cycle after the last write, so the first request can be accepted 2^ADDR_WIDTH+1 cycles after reset release.
  - Requests during INIT see req_rdy=0.
- Not defined: INIT lasts exactly one cycle after reset release with no SRAM access. init_done=1 from the second edge onward.

## Structure
- Shared package/header: FSM state encodings, default ADDR_WIDTH/WRAP_SIZE/RSP_DEPTH, and the bmask-to-WEN lane expansion constant (4 lanes).
- One sub-module: ct_f_spsram_rsp_fifo, a synchronous FIFO of depth RSP_DEPTH with push/pop/cnt, asynchronous active-low reset and head-output data.
- Top: FSM, init address counter, rd_pend, credit logic and pin drive.

## Test plan
- Init (macro on): release reset -> CEN low for 4096 consecutive cycles with A=0..4095 and D=0 -> init_done high -> random-address read returns 0x00000000.
- Write/read: write 0xDEADBEEF @0x123 with bmask=4'hF, then read @0x123 next cycle -> rsp_vld two cycles after read accept with data 0xDEADBEEF.
- Byte mask: after the above, write 0x11223344 with bmask=4'b0101, read back -> 0xDE22BE44; check WEN=0xFF00FF00 during the write.
- Backpressure: hold rsp_rdy=0 and issue 4 reads -> exactly 2 accepted and req_rdy low. Raise rsp_rdy -> responses drain in order and the remaining reads proceed at one per cycle.
- Throughput: rsp_rdy=1 with 16 back-to-back reads -> req_rdy never drops and 16 responses arrive on consecutive cycles.
- Reset mid-read: assert RST_B low the cycle after a read accept -> rsp_vld=0 and CEN=1 while in reset, and no response after release.
